div_pipelined_skid_latch: RTL and testbench
===========================================

DIV_PIPELINED_SKID_LATCH -- requirements
Module: div_pipelined_skid_latch

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the width of the partial-quotient field.
REQ-002 The block SHALL have parameter DW, default 32, giving the width of the divisor and dividend fields; the partial-remainder field SHALL be DW-1 bits.
REQ-003 The block SHALL have the following ports, one per line:
- iCLOCK  in  1  clock; all state changes on the rising edge.
- inRESET  in  1  reset; asynchronous, active-low.
- iREMOVE  in  1  synchronous flush of all held entries.
- iPREVIOUS_VALID  in  1  upstream entry present.
- oPREVIOUS_BUSY  out  1  upstream stall; driven directly from a flop.
- iPREVIOUS_SIGN  in  1  result-sign flag.
- iPREVIOUS_DIVISOR  in  DW  divisor.
- iPREVIOUS_DIVIDEND  in  DW  dividend.
- iPREVIOUS_Q  in  N  partial quotient.
- iPREVIOUS_R  in  DW-1  partial remainder.
- oNEXT_VALID  out  1  downstream entry present.
- iNEXT_BUSY  in  1  downstream stall.
- oNEXT_SIGN, oNEXT_DIVISOR, oNEXT_DIVIDEND, oNEXT_Q, oNEXT_R  out  1/DW/DW/N/DW-1  head-entry payload.
- oLEVEL  out  2  number of held entries, 0..2.

Function
REQ-004 The block SHALL hold at most two entries: MAIN, which drives the oNEXT_* outputs, and SKID; an entry is {sign, divisor, dividend, q, r}.
REQ-005 An upstream accept SHALL occur when iPREVIOUS_VALID=1 and oPREVIOUS_BUSY=0; a downstream transfer SHALL occur when oNEXT_VALID=1 and iNEXT_BUSY=0.
REQ-006 oPREVIOUS_BUSY SHALL be a registered signal equal to 1 exactly when SKID is occupied; no combinational path SHALL exist from iNEXT_BUSY to oPREVIOUS_BUSY.
REQ-007 The state machine SHALL have three states: EMPTY (oLEVEL=0), ONE (MAIN only, oLEVEL=1) and FULL (MAIN+SKID, oLEVEL=2).
REQ-008 In EMPTY, an accept SHALL load MAIN and move to ONE; otherwise the block SHALL stay in EMPTY.
REQ-009 In ONE, the transitions SHALL be:
- transfer with accept: load MAIN with the new entry, stay in ONE;
- transfer without accept: move to EMPTY;
- accept without transfer: load SKID, move to FULL;
- neither: hold.
REQ-010 In FULL, no accept SHALL occur; a transfer SHALL copy SKID into MAIN and move to ONE; otherwise the block SHALL hold.
REQ-011 Entries SHALL leave in arrival order, and each accepted entry SHALL be presented exactly once.
REQ-012 With iNEXT_BUSY=0 continuously, latency SHALL be one cycle (accept at edge k, oNEXT_VALID=1 after edge k) at a throughput of one entry per cycle.
REQ-013 Payload SHALL pass through bit-exact, with no arithmetic and no width change.
REQ-014 When an entry leaves MAIN with no replacement, the MAIN payload registers SHALL be cleared to zero.
REQ-015 When SKID is vacated, the SKID payload registers SHALL be cleared to zero.
REQ-016 iREMOVE=1 at an edge SHALL force EMPTY:
- all payload cleared, oPREVIOUS_BUSY=0, oLEVEL=0;
- any simultaneous accept or transfer is discarded;
- iREMOVE takes priority over every other input.
REQ-017 While in EMPTY, the block SHALL present oNEXT_VALID=0 and all oNEXT_* payload outputs at zero.
REQ-018 Upstream data offered while oPREVIOUS_BUSY=1 SHALL be ignored; upstream is responsible for holding it.

Reset
REQ-019 While inRESET=0, all flops SHALL clear asynchronously: oNEXT_VALID=0, oPREVIOUS_BUSY=0, oLEVEL=0, all payload outputs 0.
REQ-020 Assertion of inRESET in mid-operation SHALL drop all held entries, and operation SHALL resume from EMPTY on the first edge after release.

Verification
REQ-021 Flow-through: N=4, DW=32, iNEXT_BUSY=0, entries D=0x64,Q=0x3 then D=0x65,Q=0x4 on consecutive cycles -> each appears on oNEXT_* one cycle after its accept; oLEVEL stays 1; oPREVIOUS_BUSY stays 0.
REQ-022 Skid: hold iNEXT_BUSY=1 and offer A then B -> oLEVEL=1 then 2, oPREVIOUS_BUSY=1 after B; release iNEXT_BUSY -> A then B delivered in order; oPREVIOUS_BUSY=0 on the edge where A leaves.
REQ-023 Flush: FULL state, then iREMOVE=1 together with iPREVIOUS_VALID=1 -> next cycle oLEVEL=0, oNEXT_VALID=0, oNEXT_DIVISOR=0; the offered entry is not captured.
REQ-024 Async reset: in FULL, pull inRESET low between edges -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-025 Random stall: 1000 random entries with random iNEXT_BUSY and iPREVIOUS_VALID, N=8, DW=16 -> the scoreboard shows zero loss, zero duplication, in-order delivery, and oLEVEL never above 2.

Source files
------------

// File: rtl/div_pipelined_skid_latch.sv
// Two-entry skid latch between divider pipeline stages.
// Busy toward upstream comes from a flop, so downstream stalls never ripple combinationally.
module div_pipelined_skid_latch #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic          iCLOCK,
  input  logic          inRESET,
  input  logic          iREMOVE,
  input  logic          iPREVIOUS_VALID,
  output logic          oPREVIOUS_BUSY,
  input  logic          iPREVIOUS_SIGN,
  input  logic [DW-1:0] iPREVIOUS_DIVISOR,
  input  logic [DW-1:0] iPREVIOUS_DIVIDEND,
  input  logic [N-1:0]  iPREVIOUS_Q,
  input  logic [DW-2:0] iPREVIOUS_R,
  output logic          oNEXT_VALID,
  input  logic          iNEXT_BUSY,
  output logic          oNEXT_SIGN,
  output logic [DW-1:0] oNEXT_DIVISOR,
  output logic [DW-1:0] oNEXT_DIVIDEND,
  output logic [N-1:0]  oNEXT_Q,
  output logic [DW-2:0] oNEXT_R,
  output logic [1:0]    oLEVEL
);

  localparam int EW = 3 * DW + N;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [EW-1:0] main_q, main_n;
  logic [EW-1:0] skid_q, skid_n;
  logic [EW-1:0] in_entry;
  logic          busy_q;
  logic          accept, transfer;

  assign in_entry = {iPREVIOUS_SIGN, iPREVIOUS_DIVISOR, iPREVIOUS_DIVIDEND,
                     iPREVIOUS_Q, iPREVIOUS_R};

  assign accept   = iPREVIOUS_VALID && !busy_q;
  assign transfer = (state != EMPTY) && !iNEXT_BUSY;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      busy_q <= (state_n == FULL);
    end
  end

  // Vacated slots are zeroed so idle outputs never show stale payload.
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_n  = in_entry;
          state_n = ONE;
        end
      end
      ONE: begin
        if (transfer && accept) begin
          main_n = in_entry;
        end else if (transfer) begin
          main_n  = '0;
          state_n = EMPTY;
        end else if (accept) begin
          skid_n  = in_entry;
          state_n = FULL;
        end
      end
      FULL: begin
        if (transfer) begin
          main_n  = skid_q;
          skid_n  = '0;
          state_n = ONE;
        end
      end
      default: begin
        main_n  = '0;
        skid_n  = '0;
        state_n = EMPTY;
      end
    endcase
    if (iREMOVE) begin
      state_n = EMPTY;
      main_n  = '0;
      skid_n  = '0;
    end
  end

  assign oPREVIOUS_BUSY = busy_q;
  assign oNEXT_VALID    = (state != EMPTY);
  assign oLEVEL         = state;
  assign {oNEXT_SIGN, oNEXT_DIVISOR, oNEXT_DIVIDEND, oNEXT_Q, oNEXT_R} = main_q;

endmodule

// File: tb/tb_div_pipelined_skid_latch.sv
// Directed checks of the skid latch (N=4, DW=32) plus a random-stall
// scoreboard run on a second instance (N=8, DW=16).
module tb_div_pipelined_skid_latch;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iREMOVE = 1'b0;
  logic        iPREVIOUS_VALID = 1'b0;
  logic        iPREVIOUS_SIGN = 1'b0;
  logic [31:0] iPREVIOUS_DIVISOR = '0;
  logic [31:0] iPREVIOUS_DIVIDEND = '0;
  logic [3:0]  iPREVIOUS_Q = '0;
  logic [30:0] iPREVIOUS_R = '0;
  logic        iNEXT_BUSY = 1'b0;
  logic        oPREVIOUS_BUSY, oNEXT_VALID, oNEXT_SIGN;
  logic [31:0] oNEXT_DIVISOR, oNEXT_DIVIDEND;
  logic [3:0]  oNEXT_Q;
  logic [30:0] oNEXT_R;
  logic [1:0]  oLEVEL;

  logic        b_remove = 1'b0;
  logic        b_valid = 1'b0;
  logic        b_sign = 1'b0;
  logic [15:0] b_divisor = '0;
  logic [15:0] b_dividend = '0;
  logic [7:0]  b_q = '0;
  logic [14:0] b_r = '0;
  logic        b_next_busy = 1'b0;
  logic        b_prev_busy, b_next_valid, b_next_sign;
  logic [15:0] b_next_divisor, b_next_dividend;
  logic [7:0]  b_next_q;
  logic [14:0] b_next_r;
  logic [1:0]  b_level;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 iCLOCK = ~iCLOCK;

  div_pipelined_skid_latch #(.N(4), .DW(32)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(iREMOVE),
    .iPREVIOUS_VALID(iPREVIOUS_VALID), .oPREVIOUS_BUSY(oPREVIOUS_BUSY),
    .iPREVIOUS_SIGN(iPREVIOUS_SIGN), .iPREVIOUS_DIVISOR(iPREVIOUS_DIVISOR),
    .iPREVIOUS_DIVIDEND(iPREVIOUS_DIVIDEND), .iPREVIOUS_Q(iPREVIOUS_Q),
    .iPREVIOUS_R(iPREVIOUS_R), .oNEXT_VALID(oNEXT_VALID), .iNEXT_BUSY(iNEXT_BUSY),
    .oNEXT_SIGN(oNEXT_SIGN), .oNEXT_DIVISOR(oNEXT_DIVISOR),
    .oNEXT_DIVIDEND(oNEXT_DIVIDEND), .oNEXT_Q(oNEXT_Q), .oNEXT_R(oNEXT_R),
    .oLEVEL(oLEVEL)
  );

  div_pipelined_skid_latch #(.N(8), .DW(16)) dut_b (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE(b_remove),
    .iPREVIOUS_VALID(b_valid), .oPREVIOUS_BUSY(b_prev_busy),
    .iPREVIOUS_SIGN(b_sign), .iPREVIOUS_DIVISOR(b_divisor),
    .iPREVIOUS_DIVIDEND(b_dividend), .iPREVIOUS_Q(b_q),
    .iPREVIOUS_R(b_r), .oNEXT_VALID(b_next_valid), .iNEXT_BUSY(b_next_busy),
    .oNEXT_SIGN(b_next_sign), .oNEXT_DIVISOR(b_next_divisor),
    .oNEXT_DIVIDEND(b_next_dividend), .oNEXT_Q(b_next_q), .oNEXT_R(b_next_r),
    .oLEVEL(b_level)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic valid, input logic [1:0] level,
                            input logic busy);
    checkOutput({tag, ".valid"}, 64'(oNEXT_VALID), 64'(valid));
    checkOutput({tag, ".level"}, 64'(oLEVEL), 64'(level));
    checkOutput({tag, ".busy"}, 64'(oPREVIOUS_BUSY), 64'(busy));
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] dvs, input logic [31:0] dvd,
                               input logic [3:0] qq, input logic nbusy);
    iPREVIOUS_VALID    = valid;
    iPREVIOUS_SIGN     = dvd[0];
    iPREVIOUS_DIVISOR  = dvs;
    iPREVIOUS_DIVIDEND = dvd;
    iPREVIOUS_Q        = qq;
    iPREVIOUS_R        = {dvs[14:0], dvd[15:0]};
    iNEXT_BUSY         = nbusy;
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [55:0] cur, exp_p, obs_p;
    logic [55:0] exp_q[$];
    logic        acc, xfer;
    int sent, got, cycles;

    #2;
    checkState("reset", 1'b0, 2'd0, 1'b0);
    checkOutput("reset.divisor", 64'(oNEXT_DIVISOR), 64'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    tick();

    // Flow-through with no downstream stall
    applyStimulus(1'b1, 32'h7, 32'h64, 4'h3, 1'b0);
    tick();
    checkState("flow1", 1'b1, 2'd1, 1'b0);
    checkOutput("flow1.dividend", 64'(oNEXT_DIVIDEND), 64'h64);
    checkOutput("flow1.q", 64'(oNEXT_Q), 64'h3);
    checkOutput("flow1.r", 64'(oNEXT_R), 64'h0007_0064);
    applyStimulus(1'b1, 32'h9, 32'h65, 4'h4, 1'b0);
    tick();
    checkState("flow2", 1'b1, 2'd1, 1'b0);
    checkOutput("flow2.dividend", 64'(oNEXT_DIVIDEND), 64'h65);
    checkOutput("flow2.q", 64'(oNEXT_Q), 64'h4);
    checkOutput("flow2.sign", 64'(oNEXT_SIGN), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checkState("drain", 1'b0, 2'd0, 1'b0);
    checkOutput("drain.dividend", 64'(oNEXT_DIVIDEND), 64'd0);

    // Skid: stall downstream, fill both slots, then drain in order
    applyStimulus(1'b1, 32'h11, 32'hA0, 4'h5, 1'b1);
    tick();
    checkState("skidA", 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 32'h12, 32'hB0, 4'h6, 1'b1);
    tick();
    checkState("skidB", 1'b1, 2'd2, 1'b1);
    checkOutput("skidB.dividend", 64'(oNEXT_DIVIDEND), 64'hA0);
    applyStimulus(1'b1, 32'h13, 32'hC0, 4'h7, 1'b1);
    tick();
    checkState("skidC_ignored", 1'b1, 2'd2, 1'b1);
    checkOutput("skidC.dividend", 64'(oNEXT_DIVIDEND), 64'hA0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checkState("releaseA", 1'b1, 2'd1, 1'b0);
    checkOutput("releaseA.dividend", 64'(oNEXT_DIVIDEND), 64'hB0);
    checkOutput("releaseA.q", 64'(oNEXT_Q), 64'h6);
    checkOutput("releaseA.divisor", 64'(oNEXT_DIVISOR), 64'h12);
    tick();
    checkState("releaseB", 1'b0, 2'd0, 1'b0);
    checkOutput("releaseB.q", 64'(oNEXT_Q), 64'd0);

    // Flush from FULL with a simultaneous offer
    applyStimulus(1'b1, 32'h21, 32'h1A, 4'h1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h22, 32'h1B, 4'h2, 1'b1);
    tick();
    checkState("preflush", 1'b1, 2'd2, 1'b1);
    iREMOVE = 1'b1;
    applyStimulus(1'b1, 32'h23, 32'h1C, 4'h3, 1'b0);
    tick();
    checkState("flush", 1'b0, 2'd0, 1'b0);
    checkOutput("flush.divisor", 64'(oNEXT_DIVISOR), 64'd0);
    tick();
    checkState("flush_accept_dropped", 1'b0, 2'd0, 1'b0);
    iREMOVE = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();
    checkState("postflush", 1'b0, 2'd0, 1'b0);

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 32'h31, 32'h2A, 4'h1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h32, 32'h2B, 4'h2, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    #2;
    inRESET = 1'b0;
    #1;
    checkState("async_reset", 1'b0, 2'd0, 1'b0);
    checkOutput("async_reset.divisor", 64'(oNEXT_DIVISOR), 64'd0);
    checkOutput("async_reset.dividend", 64'(oNEXT_DIVIDEND), 64'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    applyStimulus(1'b1, 32'h41, 32'h3A, 4'h9, 1'b1);
    tick();
    checkState("resume", 1'b1, 2'd1, 1'b0);
    checkOutput("resume.dividend", 64'(oNEXT_DIVIDEND), 64'h3A);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    tick();

    // Random stall scoreboard on the N=8, DW=16 instance
    sent = 0;
    got = 0;
    cycles = 0;
    rnd = {$urandom(), $urandom()};
    cur = rnd[55:0];
    {b_sign, b_divisor, b_dividend, b_q, b_r} = cur;
    b_valid = 1'b1;
    b_next_busy = 1'b0;
    while (got < 1000 && cycles < 20000) begin
      acc  = b_valid && !b_prev_busy;
      xfer = b_next_valid && !b_next_busy;
      if (xfer) begin
        checkOutput("rand.nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_p = exp_q.pop_front();
          obs_p = {b_next_sign, b_next_divisor, b_next_dividend, b_next_q, b_next_r};
          checkOutput("rand.payload", 64'(obs_p), 64'(exp_p));
        end
        got++;
      end
      tick();
      if (acc) begin
        exp_q.push_back(cur);
        sent++;
        rnd = {$urandom(), $urandom()};
        cur = rnd[55:0];
        {b_sign, b_divisor, b_dividend, b_q, b_r} = cur;
      end
      checkOutput("rand.level", 64'(b_level), 64'(exp_q.size()));
      b_valid     = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_next_busy = ($urandom_range(0, 2) == 0);
      cycles++;
    end
    checkOutput("rand.delivered", 64'(got), 64'd1000);
    checkOutput("rand.sent", 64'(sent), 64'd1000);
    checkOutput("rand.final_level", 64'(b_level), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
